// File: rtl/bcd_serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_serial_add_ctrl_if
//  Description : Handshake and operand/result bundle for bcd_serial_add_ctrl.
//                The sub signal exists only when BCD_SUB_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface bcd_serial_add_ctrl_if #(
    parameter int NDIG = 4
);
    logic                start;
    logic [4*NDIG-1:0]   a;
    logic [4*NDIG-1:0]   b;
    logic                cin;
`ifdef BCD_SUB_EN
    logic                sub;
`endif
    logic                busy;
    logic                done;
    logic [4*NDIG-1:0]   sum;
    logic                cout;
    logic                err;

    // Requester side: drives the operands and start, observes the result.
    modport master (
        output start, a, b, cin,
`ifdef BCD_SUB_EN
        output sub,
`endif
        input  busy, done, sum, cout, err
    );

    // Sequencer side.
    modport slave (
        input  start, a, b, cin,
`ifdef BCD_SUB_EN
        input  sub,
`endif
        output busy, done, sum, cout, err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_serial_add_ctrl
//  Description : Digit-serial packed-BCD adder. One 4-bit add/correct stage is
//                reused NDIG times, LSD first, with the decimal carry held in a
//                register. Start/busy/done handshake.
//                Optional macro BCD_SUB_EN adds a sub input (a - b by nines
//                complement of b plus a forced carry-in of 1).
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_serial_add_ctrl #(
    parameter int NDIG = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    bcd_serial_add_ctrl_if.slave  bus
);
    localparam int W  = 4 * NDIG;
    localparam int CW = $clog2(NDIG + 1);
    localparam logic [CW-1:0] C_LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q,  state_d;
    logic [W-1:0]    a_sh_q,   a_sh_d;
    logic [W-1:0]    b_sh_q,   b_sh_d;
    logic            carry_q,  carry_d;
    logic [CW-1:0]   count_q,  count_d;
    logic [W-1:0]    sum_q,    sum_d;
    logic            cout_q,   cout_d;
    logic            err_q,    err_d;
    logic            busy_q,   busy_d;
    logic            done_q,   done_d;

    // Per-digit validity of the incoming operands (always the original b).
    logic [NDIG-1:0] a_bad;
    logic [NDIG-1:0] b_bad;
    logic            sub_sel;
    logic [W-1:0]    b_load;

    for (genvar i = 0; i < NDIG; i++) begin : g_digit_chk
        assign a_bad[i] = (bus.a[4*i +: 4] > 4'd9);
        assign b_bad[i] = (bus.b[4*i +: 4] > 4'd9);
    end

`ifdef BCD_SUB_EN
    logic [W-1:0] b_nines;
    for (genvar i = 0; i < NDIG; i++) begin : g_nines
        assign b_nines[4*i +: 4] = 4'd9 - bus.b[4*i +: 4];
    end
    assign sub_sel = bus.sub;
    assign b_load  = bus.sub ? b_nines : bus.b;
`else
    assign sub_sel = 1'b0;
    assign b_load  = bus.b;
`endif

    // Single-digit BCD add and +6 correction on the current LSDs.
    logic [4:0]   dig_sum;
    logic         dig_gt9;
    logic [3:0]   dig_res;
    logic [W+3:0] sum_shift;

    always_comb begin
        dig_sum   = {1'b0, a_sh_q[3:0]} + {1'b0, b_sh_q[3:0]} + {4'b0000, carry_q};
        dig_gt9   = (dig_sum > 5'd9);
        dig_res   = dig_gt9 ? (dig_sum[3:0] + 4'd6) : dig_sum[3:0];
        sum_shift = {dig_res, sum_q};
    end

    // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        count_d = count_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    a_sh_d  = bus.a;
                    b_sh_d  = b_load;
                    carry_d = sub_sel ? 1'b1 : bus.cin;
                    count_d = '0;
                    err_d   = (|a_bad) | (|b_bad);
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                // New digit enters at the MSD side; after NDIG shifts the
                // first digit computed sits in sum[3:0].
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                carry_d = dig_gt9;
                sum_d   = sum_shift[W+3:4];
                count_d = count_q + 1'b1;
                if (count_q == C_LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cout_d  = dig_gt9;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; asynchronous reset aborts any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_serial_add_ctrl
//  Description : Directed self-checking bench for bcd_serial_add_ctrl with
//                NDIG=2 and NDIG=4 instances. Subtraction vectors are active
//                when BCD_SUB_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bcd_serial_add_ctrl_if #(.NDIG(2)) if2 ();
    bcd_serial_add_ctrl_if #(.NDIG(4)) if4 ();

    bcd_serial_add_ctrl #(.NDIG(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
    bcd_serial_add_ctrl #(.NDIG(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (at negedges) until done; lat = clock edges after the accept edge.
    task automatic wait_done2(output int lat);
        lat = 0;
        while (if2.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // One NDIG=2 transaction; operands are scrambled right after acceptance.
    task automatic op2(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic tcin, input logic tsub,
                       input logic [7:0] esum, input logic ecout, input logic eerr);
        int lat;
        @(negedge clk);
        if2.start = 1'b1;
        if2.a     = ta;
        if2.b     = tb_v;
        if2.cin   = tcin;
`ifdef BCD_SUB_EN
        if2.sub   = tsub;
`else
        if (tsub) $display("note: sub vector %s run as add", tag);
`endif
        @(posedge clk);
        @(negedge clk);
        if2.start = 1'b0;
        if2.a     = 8'h77;
        if2.b     = 8'h33;
        if2.cin   = ~tcin;
`ifdef BCD_SUB_EN
        if2.sub   = ~tsub;
`endif
        check_val({tag, "_busy"}, if2.busy, 1'b1);
        wait_done2(lat);
        // done is visible after the NDIG-th edge past acceptance.
        check_val({tag, "_lat"},  lat, 2);
        check_val({tag, "_sum"},  if2.sum, esum);
        check_val({tag, "_cout"}, if2.cout, ecout);
        check_val({tag, "_err"},  if2.err, eerr);
        @(negedge clk);
        check_val({tag, "_pulse"}, if2.done, 1'b0);
        repeat (2) @(negedge clk);
        check_val({tag, "_hold"}, {if2.busy, if2.cout, if2.sum}, {1'b0, ecout, esum});
    endtask

    initial begin
        int lat;
        int ndone;
        if2.start = 1'b0; if2.a = '0; if2.b = '0; if2.cin = 1'b0;
        if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
`ifdef BCD_SUB_EN
        if2.sub = 1'b0;
        if4.sub = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_state", {if2.busy, if2.done, if2.cout, if2.err, if2.sum}, 12'h000);
        check_val("rst_state4", {if4.busy, if4.done, if4.cout, if4.err, if4.sum}, 20'h00000);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_val("idle_nostart", if2.busy, 1'b0);

        // Basic adds and corner values.
        op2("add42_59", 8'h42, 8'h59, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0);
        op2("add99_99", 8'h99, 8'h99, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0);
        op2("add00_00", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        op2("add12_37", 8'h12, 8'h37, 1'b0, 1'b0, 8'h49, 1'b0, 1'b0);
        // Invalid digit A: 0xA+1=11 -> 1 carry 1; 4+0+1 = 5.
        op2("err4A",    8'h4A, 8'h01, 1'b0, 1'b0, 8'h51, 1'b0, 1'b1);
        op2("err_clr",  8'h40, 8'h01, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0);

        // start held during RUN with new operands must be ignored.
        @(negedge clk);
        if2.start = 1'b1; if2.a = 8'h12; if2.b = 8'h34; if2.cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if2.a = 8'h99; if2.b = 8'h99; if2.cin = 1'b1;
        ndone = 0;
        wait_done2(lat);
        if (if2.done === 1'b1) ndone++;
        if2.start = 1'b0;
        check_val("hold_lat",  lat, 2);
        check_val("hold_sum",  if2.sum, 8'h46);
        check_val("hold_cout", if2.cout, 1'b0);
        repeat (4) begin
            @(negedge clk);
            if (if2.done === 1'b1) ndone++;
        end
        check_val("hold_onedone", ndone, 1);
        check_val("hold_idle", if2.busy, 1'b0);

        // Reset during the second RUN cycle aborts with no done pulse.
        @(negedge clk);
        if2.start = 1'b1; if2.a = 8'h11; if2.b = 8'h22; if2.cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if2.start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("abort_out", {if2.busy, if2.done, if2.cout, if2.err, if2.sum}, 12'h000);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (4) begin
            @(negedge clk);
            if (if2.done === 1'b1) ndone++;
        end
        check_val("abort_nodone", ndone, 0);
        op2("after_rst", 8'h58, 8'h27, 1'b1, 1'b0, 8'h86, 1'b0, 1'b0);

`ifdef BCD_SUB_EN
        // cin is ignored in subtract mode (driven to 0 here).
        op2("sub59_42", 8'h59, 8'h42, 1'b0, 1'b1, 8'h17, 1'b1, 1'b0);
        op2("sub42_59", 8'h42, 8'h59, 1'b0, 1'b1, 8'h83, 1'b0, 1'b0);
`endif

        // NDIG=4: 9999 + 0001 wraps to 0000 with carry out.
        @(negedge clk);
        if4.start = 1'b1; if4.a = 16'h9999; if4.b = 16'h0001; if4.cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if4.start = 1'b0; if4.a = 16'h1234; if4.b = 16'h5678;
        lat = 0;
        while (if4.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_val("n4_lat",  lat, 4);
        check_val("n4_sum",  if4.sum, 16'h0000);
        check_val("n4_cout", if4.cout, 1'b1);
        check_val("n4_err",  if4.err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
